// File: rtl/id_ex_reg_pkg.sv
// Shared widths, control-word layout and stage actions for the ID/EX pipeline register.
// The bubble constants define what EX sees when no real instruction is present.
package id_ex_reg_pkg;

  localparam int NB_DATA   = 32;
  localparam int NB_REG    = 5;
  localparam int NB_OPCODE = 6;
  localparam int NB_CNT    = 16;

  localparam logic [NB_OPCODE-1:0] ALU_OP_NOP = '0;

  typedef struct packed {
    logic reg_dest;
    logic alu_src;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic reg_write;
    logic mem_to_reg;
    logic byte_en;
    logic halfword_en;
    logic word_en;
    logic jr_jalr;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // What the stage does on the next rising edge, in decreasing priority.
  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_FLUSH,
    ACT_STALL,
    ACT_CAPTURE
  } action_e;

endpackage

// File: rtl/id_ex_reg_if.sv
// Bundle of ID-side inputs and EX-side outputs of the ID/EX register.
// The slave modport is the register itself; master is whoever drives ID.
interface id_ex_reg_if #(
  parameter int NB_DATA   = id_ex_reg_pkg::NB_DATA,
  parameter int NB_REG    = id_ex_reg_pkg::NB_REG,
  parameter int NB_OPCODE = id_ex_reg_pkg::NB_OPCODE,
  parameter int NB_CNT    = id_ex_reg_pkg::NB_CNT
);

  logic                 i_enable;
  logic                 i_flush;
  logic                 i_reg_dest, i_alu_src, i_mem_read, i_mem_write, i_branch, i_reg_write;
  logic                 i_mem_to_reg, i_byte_en, i_halfword_en, i_word_en, i_jr_jalr;
  logic [NB_OPCODE-1:0] i_alu_op;
  logic [NB_DATA-1:0]   i_pc, i_data_a, i_data_b, i_immediate;
  logic [NB_REG-1:0]    i_rs, i_rt, i_rd;

  logic                 o_reg_dest, o_alu_src, o_mem_read, o_mem_write, o_branch, o_reg_write;
  logic                 o_mem_to_reg, o_byte_en, o_halfword_en, o_word_en, o_jr_jalr;
  logic [NB_OPCODE-1:0] o_alu_op;
  logic [NB_DATA-1:0]   o_pc, o_data_a, o_data_b, o_immediate;
  logic [NB_REG-1:0]    o_rs, o_rt, o_rd;
  logic                 o_valid;
  logic                 o_stall;
  logic [NB_CNT-1:0]    o_bubble_count;

  modport slave (
    input  i_enable, i_flush,
    input  i_reg_dest, i_alu_src, i_mem_read, i_mem_write, i_branch, i_reg_write,
    input  i_mem_to_reg, i_byte_en, i_halfword_en, i_word_en, i_jr_jalr,
    input  i_alu_op, i_pc, i_data_a, i_data_b, i_immediate, i_rs, i_rt, i_rd,
    output o_reg_dest, o_alu_src, o_mem_read, o_mem_write, o_branch, o_reg_write,
    output o_mem_to_reg, o_byte_en, o_halfword_en, o_word_en, o_jr_jalr,
    output o_alu_op, o_pc, o_data_a, o_data_b, o_immediate, o_rs, o_rt, o_rd,
    output o_valid, o_stall, o_bubble_count
  );

  modport master (
    output i_enable, i_flush,
    output i_reg_dest, i_alu_src, i_mem_read, i_mem_write, i_branch, i_reg_write,
    output i_mem_to_reg, i_byte_en, i_halfword_en, i_word_en, i_jr_jalr,
    output i_alu_op, i_pc, i_data_a, i_data_b, i_immediate, i_rs, i_rt, i_rd,
    input  o_reg_dest, o_alu_src, o_mem_read, o_mem_write, o_branch, o_reg_write,
    input  o_mem_to_reg, o_byte_en, o_halfword_en, o_word_en, o_jr_jalr,
    input  o_alu_op, o_pc, o_data_a, o_data_b, o_immediate, o_rs, o_rt, o_rd,
    input  o_valid, o_stall, o_bubble_count
  );

endinterface

// File: rtl/id_ex_reg_load_use_detect.sv
// Load-use comparator: a load in EX whose destination is read by the instruction in ID.
// A destination of $zero never creates a dependency.
module id_ex_reg_load_use_detect #(
  parameter int NB_REG = id_ex_reg_pkg::NB_REG
) (
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [NB_REG-1:0] ex_rt_i,
  input  logic [NB_REG-1:0] id_rs_i,
  input  logic [NB_REG-1:0] id_rt_i,
  output logic              hz_o
);

  logic rt_nonzero;
  logic rt_match;

  assign rt_nonzero = |ex_rt_i;
  assign rt_match   = (ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i);
  assign hz_o       = ex_valid_i & ex_mem_read_i & rt_nonzero & rt_match;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use stall, bubble injection and a
// saturating bubble counter for the debug unit.
module id_ex_reg #(
  parameter int NB_DATA   = id_ex_reg_pkg::NB_DATA,
  parameter int NB_REG    = id_ex_reg_pkg::NB_REG,
  parameter int NB_OPCODE = id_ex_reg_pkg::NB_OPCODE,
  parameter int NB_CNT    = id_ex_reg_pkg::NB_CNT
) (
  input  logic       i_clock,
  input  logic       i_reset,
  id_ex_reg_if.slave bus
);

  import id_ex_reg_pkg::*;

  ctrl_t                ctrl_in, ctrl_q, ctrl_d;
  logic [NB_OPCODE-1:0] alu_op_q, alu_op_d;
  logic [NB_DATA-1:0]   pc_q, pc_d;
  logic [NB_DATA-1:0]   data_a_q, data_a_d;
  logic [NB_DATA-1:0]   data_b_q, data_b_d;
  logic [NB_DATA-1:0]   imm_q, imm_d;
  logic [NB_REG-1:0]    rs_q, rs_d;
  logic [NB_REG-1:0]    rt_q, rt_d;
  logic [NB_REG-1:0]    rd_q, rd_d;
  logic                 valid_q, valid_d;
  logic [NB_CNT-1:0]    cnt_q, cnt_d;
  logic                 hz;
  action_e              action;

  assign ctrl_in = '{
    reg_dest:    bus.i_reg_dest,
    alu_src:     bus.i_alu_src,
    mem_read:    bus.i_mem_read,
    mem_write:   bus.i_mem_write,
    branch:      bus.i_branch,
    reg_write:   bus.i_reg_write,
    mem_to_reg:  bus.i_mem_to_reg,
    byte_en:     bus.i_byte_en,
    halfword_en: bus.i_halfword_en,
    word_en:     bus.i_word_en,
    jr_jalr:     bus.i_jr_jalr
  };

  id_ex_reg_load_use_detect #(
    .NB_REG (NB_REG)
  ) u_load_use_detect (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_rt_i       (rt_q),
    .id_rs_i       (bus.i_rs),
    .id_rt_i       (bus.i_rt),
    .hz_o          (hz)
  );

  // A flush already squashes ID, so it must not also hold PC and IF/ID.
  assign bus.o_stall = hz & bus.i_enable & ~bus.i_flush;

  always_comb begin
    action = ACT_CAPTURE;
    if (!bus.i_enable) begin
      action = ACT_HOLD;
    end else if (bus.i_flush) begin
      action = ACT_FLUSH;
    end else if (hz) begin
      action = ACT_STALL;
    end
  end

  always_comb begin
    // NOTE: every next-state signal is given a hold default first so no latch is inferred.
    ctrl_d   = ctrl_q;
    alu_op_d = alu_op_q;
    pc_d     = pc_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    imm_d    = imm_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rd_d     = rd_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;

    unique case (action)
      ACT_HOLD: begin
      end
      ACT_FLUSH, ACT_STALL: begin
        ctrl_d   = CTRL_BUBBLE;
        alu_op_d = NB_OPCODE'(ALU_OP_NOP);
        pc_d     = '0;
        data_a_d = '0;
        data_b_d = '0;
        imm_d    = '0;
        rs_d     = '0;
        rt_d     = '0;
        rd_d     = '0;
        valid_d  = 1'b0;
        // Only hazard bubbles are counted; the counter sticks at all-ones.
        if ((action == ACT_STALL) && (cnt_q != '1)) begin
          cnt_d = cnt_q + NB_CNT'(1);
        end
      end
      ACT_CAPTURE: begin
        ctrl_d   = ctrl_in;
        alu_op_d = bus.i_alu_op;
        pc_d     = bus.i_pc;
        data_a_d = bus.i_data_a;
        data_b_d = bus.i_data_b;
        imm_d    = bus.i_immediate;
        rs_d     = bus.i_rs;
        rt_d     = bus.i_rt;
        rd_d     = bus.i_rd;
        valid_d  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      // NOTE: non-blocking so every register samples pre-edge values of its peers.
      ctrl_q   <= CTRL_BUBBLE;
      alu_op_q <= '0;
      pc_q     <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
      imm_q    <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      alu_op_q <= alu_op_d;
      pc_q     <= pc_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      imm_q    <= imm_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.o_reg_dest     = ctrl_q.reg_dest;
  assign bus.o_alu_src      = ctrl_q.alu_src;
  assign bus.o_mem_read     = ctrl_q.mem_read;
  assign bus.o_mem_write    = ctrl_q.mem_write;
  assign bus.o_branch       = ctrl_q.branch;
  assign bus.o_reg_write    = ctrl_q.reg_write;
  assign bus.o_mem_to_reg   = ctrl_q.mem_to_reg;
  assign bus.o_byte_en      = ctrl_q.byte_en;
  assign bus.o_halfword_en  = ctrl_q.halfword_en;
  assign bus.o_word_en      = ctrl_q.word_en;
  assign bus.o_jr_jalr      = ctrl_q.jr_jalr;
  assign bus.o_alu_op       = alu_op_q;
  assign bus.o_pc           = pc_q;
  assign bus.o_data_a       = data_a_q;
  assign bus.o_data_b       = data_b_q;
  assign bus.o_immediate    = imm_q;
  assign bus.o_rs           = rs_q;
  assign bus.o_rt           = rt_q;
  assign bus.o_rd           = rd_q;
  assign bus.o_valid        = valid_q;
  assign bus.o_bubble_count = cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: a transaction-level model of the EX contents and bubble count,
// directed pipeline scenarios, then randomized traffic. A 2-bit-counter copy shows saturation.
module tb_id_ex_reg;

  import id_ex_reg_pkg::*;

  typedef struct {
    logic        enable;
    logic        flush;
    ctrl_t       ctrl;
    logic [5:0]  alu_op;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  rs, rt, rd;
  } stim_t;

  typedef struct {
    ctrl_t       ctrl;
    logic [5:0]  alu_op;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  rs, rt, rd;
    logic        valid;
  } ex_t;

  logic  clk   = 1'b0;
  logic  rst_n = 1'b0;
  stim_t cur;
  ex_t   m;
  int    m_cnt  = 0;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  id_ex_reg_if bus ();
  id_ex_reg_if #(.NB_CNT(2)) bus_s ();

  assign bus_s.i_enable      = bus.i_enable;
  assign bus_s.i_flush       = bus.i_flush;
  assign bus_s.i_reg_dest    = bus.i_reg_dest;
  assign bus_s.i_alu_src     = bus.i_alu_src;
  assign bus_s.i_mem_read    = bus.i_mem_read;
  assign bus_s.i_mem_write   = bus.i_mem_write;
  assign bus_s.i_branch      = bus.i_branch;
  assign bus_s.i_reg_write   = bus.i_reg_write;
  assign bus_s.i_mem_to_reg  = bus.i_mem_to_reg;
  assign bus_s.i_byte_en     = bus.i_byte_en;
  assign bus_s.i_halfword_en = bus.i_halfword_en;
  assign bus_s.i_word_en     = bus.i_word_en;
  assign bus_s.i_jr_jalr     = bus.i_jr_jalr;
  assign bus_s.i_alu_op      = bus.i_alu_op;
  assign bus_s.i_pc          = bus.i_pc;
  assign bus_s.i_data_a      = bus.i_data_a;
  assign bus_s.i_data_b      = bus.i_data_b;
  assign bus_s.i_immediate   = bus.i_immediate;
  assign bus_s.i_rs          = bus.i_rs;
  assign bus_s.i_rt          = bus.i_rt;
  assign bus_s.i_rd          = bus.i_rd;

  id_ex_reg dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus.slave)
  );

  id_ex_reg #(.NB_CNT(2)) dut_s (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus_s.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input stim_t s);
    cur               = s;
    bus.i_enable      = s.enable;
    bus.i_flush       = s.flush;
    bus.i_reg_dest    = s.ctrl.reg_dest;
    bus.i_alu_src     = s.ctrl.alu_src;
    bus.i_mem_read    = s.ctrl.mem_read;
    bus.i_mem_write   = s.ctrl.mem_write;
    bus.i_branch      = s.ctrl.branch;
    bus.i_reg_write   = s.ctrl.reg_write;
    bus.i_mem_to_reg  = s.ctrl.mem_to_reg;
    bus.i_byte_en     = s.ctrl.byte_en;
    bus.i_halfword_en = s.ctrl.halfword_en;
    bus.i_word_en     = s.ctrl.word_en;
    bus.i_jr_jalr     = s.ctrl.jr_jalr;
    bus.i_alu_op      = s.alu_op;
    bus.i_pc          = s.pc;
    bus.i_data_a      = s.a;
    bus.i_data_b      = s.b;
    bus.i_immediate   = s.imm;
    bus.i_rs          = s.rs;
    bus.i_rt          = s.rt;
    bus.i_rd          = s.rd;
  endtask

  // New ID contents arrive on the falling edge; directed checks run just after.
  task automatic drive(input stim_t s);
    @(negedge clk);
    apply(s);
    #2;
  endtask

  function automatic stim_t nop();
    stim_t s;
    s.enable = 1'b1; s.flush = 1'b0; s.ctrl = '0; s.alu_op = '0;
    s.pc = 32'h100; s.a = 32'h0; s.b = 32'h0; s.imm = 32'h0;
    s.rs = '0; s.rt = '0; s.rd = '0;
    return s;
  endfunction

  function automatic stim_t lw(input logic [4:0] rs, input logic [4:0] rt);
    stim_t s = nop();
    s.ctrl.mem_read = 1'b1; s.ctrl.mem_to_reg = 1'b1; s.ctrl.alu_src = 1'b1;
    s.ctrl.reg_write = 1'b1; s.ctrl.word_en = 1'b1;
    s.alu_op = 6'h20; s.rs = rs; s.rt = rt; s.imm = 32'h4; s.a = 32'h1000;
    return s;
  endfunction

  function automatic stim_t rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    stim_t s = nop();
    s.ctrl.reg_dest = 1'b1; s.ctrl.reg_write = 1'b1;
    s.alu_op = 6'h21; s.rs = rs; s.rt = rt; s.rd = rd; s.a = 32'h11; s.b = 32'h22;
    return s;
  endfunction

  function automatic stim_t addi(input logic [4:0] rt, input logic [31:0] imm);
    stim_t s = nop();
    s.ctrl.alu_src = 1'b1; s.ctrl.reg_write = 1'b1;
    s.alu_op = 6'h08; s.rt = rt; s.imm = imm; s.pc = 32'h204;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    logic [10:0] c;
    c = 11'($urandom);
    c[8] = ($urandom % 5) < 2;
    s.enable = ($urandom % 10) != 0;
    s.flush  = ($urandom % 8) == 0;
    s.ctrl   = c;
    s.alu_op = 6'($urandom);
    s.pc = $urandom; s.a = $urandom; s.b = $urandom; s.imm = $urandom;
    s.rs = 5'($urandom % 4); s.rt = 5'($urandom % 4); s.rd = 5'($urandom);
    return s;
  endfunction

  // ---------------- behavioural model ----------------
  function automatic ex_t bubble();
    ex_t e;
    e.ctrl = '0; e.alu_op = '0; e.pc = '0; e.a = '0; e.b = '0; e.imm = '0;
    e.rs = '0; e.rt = '0; e.rd = '0; e.valid = 1'b0;
    return e;
  endfunction

  function automatic ex_t capture(input stim_t s);
    ex_t e;
    e.ctrl = s.ctrl; e.alu_op = s.alu_op; e.pc = s.pc; e.a = s.a; e.b = s.b;
    e.imm = s.imm; e.rs = s.rs; e.rt = s.rt; e.rd = s.rd; e.valid = 1'b1;
    return e;
  endfunction

  function automatic logic model_hz(input ex_t e, input stim_t s);
    return e.valid && e.ctrl.mem_read && (e.rt != '0) && ((e.rt == s.rs) || (e.rt == s.rt));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m     <= bubble();
      m_cnt <= 0;
    end else if (cur.enable) begin
      if (cur.flush) begin
        m <= bubble();
      end else if (model_hz(m, cur)) begin
        m     <= bubble();
        m_cnt <= m_cnt + 1;
      end else begin
        m <= capture(cur);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic compare_all();
    ctrl_t       act;
    logic [15:0] e16;
    logic [1:0]  e2;
    logic        e_stall;
    act = '{bus.o_reg_dest, bus.o_alu_src, bus.o_mem_read, bus.o_mem_write, bus.o_branch,
            bus.o_reg_write, bus.o_mem_to_reg, bus.o_byte_en, bus.o_halfword_en,
            bus.o_word_en, bus.o_jr_jalr};
    e16     = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
    e2      = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
    e_stall = model_hz(m, cur) && cur.enable && !cur.flush;
    check("ctrl",      {21'b0, act},             {21'b0, m.ctrl});
    check("alu_op",    32'(bus.o_alu_op),        32'(m.alu_op));
    check("pc",        bus.o_pc,                 m.pc);
    check("data_a",    bus.o_data_a,             m.a);
    check("data_b",    bus.o_data_b,             m.b);
    check("immediate", bus.o_immediate,          m.imm);
    check("rs",        32'(bus.o_rs),            32'(m.rs));
    check("rt",        32'(bus.o_rt),            32'(m.rt));
    check("rd",        32'(bus.o_rd),            32'(m.rd));
    check("valid",     32'(bus.o_valid),         32'(m.valid));
    check("stall",     32'(bus.o_stall),         32'(e_stall));
    check("count",     32'(bus.o_bubble_count),  32'(e16));
    check("count_sat", 32'(bus_s.o_bubble_count), 32'(e2));
    check("stall_sat", 32'(bus_s.o_stall),       32'(e_stall));
  endtask

  always @(negedge clk) begin
    #1;
    compare_all();
  end

  // ---------------- stimulus ----------------
  initial begin
    stim_t s;
    apply(nop());
    repeat (2) @(negedge clk);
    #2;
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_count", 32'(bus.o_bubble_count), 32'd0);
    check("rst_stall", 32'(bus.o_stall), 32'd0);

    rst_n = 1'b1;
    drive(addi(5'd5, 32'h10));
    drive(lw(5'd1, 5'd8));
    check("addi_alu_src",   32'(bus.o_alu_src), 32'd1);
    check("addi_reg_write", 32'(bus.o_reg_write), 32'd1);
    check("addi_rt",        32'(bus.o_rt), 32'd5);
    check("addi_imm",       bus.o_immediate, 32'h10);
    check("addi_valid",     32'(bus.o_valid), 32'd1);
    check("addi_stall",     32'(bus.o_stall), 32'd0);

    drive(rtype(5'd8, 5'd9, 5'd10));
    check("lw_mem_read", 32'(bus.o_mem_read), 32'd1);
    check("lu_stall",    32'(bus.o_stall), 32'd1);
    drive(rtype(5'd8, 5'd9, 5'd10));
    check("bubble_valid", 32'(bus.o_valid), 32'd0);
    check("bubble_rw",    32'(bus.o_reg_write), 32'd0);
    check("bubble_count", 32'(bus.o_bubble_count), 32'd1);
    check("model_count",  32'(m_cnt), 32'd1);
    check("stall_once",   32'(bus.o_stall), 32'd0);
    drive(nop());
    check("rtype_valid", 32'(bus.o_valid), 32'd1);
    check("rtype_rd",    32'(bus.o_rd), 32'd10);

    drive(lw(5'd2, 5'd0));
    drive(rtype(5'd0, 5'd0, 5'd3));
    check("zero_stall", 32'(bus.o_stall), 32'd0);
    drive(nop());
    check("zero_valid", 32'(bus.o_valid), 32'd1);
    check("zero_count", 32'(bus.o_bubble_count), 32'd1);

    drive(lw(5'd2, 5'd3));
    s = rtype(5'd3, 5'd4, 5'd5);
    s.flush = 1'b1;
    drive(s);
    check("flush_stall", 32'(bus.o_stall), 32'd0);
    drive(nop());
    check("flush_valid", 32'(bus.o_valid), 32'd0);
    check("flush_count", 32'(bus.o_bubble_count), 32'd1);

    drive(addi(5'd7, 32'h77));
    for (int i = 0; i < 3; i++) begin
      s = rand_stim();
      s.enable = 1'b0;
      drive(s);
      check("frz_rt",    32'(bus.o_rt), 32'd7);
      check("frz_imm",   bus.o_immediate, 32'h77);
      check("frz_count", 32'(bus.o_bubble_count), 32'd1);
    end
    drive(nop());
    check("frz_last", 32'(bus.o_rt), 32'd7);
    drive(nop());
    check("resume_rt", 32'(bus.o_rt), 32'd0);

    for (int i = 0; i < 4; i++) begin
      drive(lw(5'd1, 5'd4));
      drive(rtype(5'd4, 5'd1, 5'd6));
      drive(rtype(5'd4, 5'd1, 5'd6));
    end
    drive(nop());
    check("sat_count16", 32'(bus.o_bubble_count), 32'd5);
    check("sat_count2",  32'(bus_s.o_bubble_count), 32'd3);

    drive(lw(5'd1, 5'd6));
    drive(rtype(5'd6, 5'd1, 5'd2));
    check("pre_rst_stall", 32'(bus.o_stall), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_stall",    32'(bus.o_stall), 32'd0);
    check("arst_valid",    32'(bus.o_valid), 32'd0);
    check("arst_mem_read", 32'(bus.o_mem_read), 32'd0);
    check("arst_rt",       32'(bus.o_rt), 32'd0);
    check("arst_count",    32'(bus.o_bubble_count), 32'd0);
    check("arst_count2",   32'(bus_s.o_bubble_count), 32'd0);
    drive(nop());
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      drive(rand_stim());
    end
    drive(nop());
    drive(nop());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
